multicycle_ctrl: RTL and testbench

Multi-cycle MIPS controller FSM. It sequences the shared single-ALU/single-memory datapath through fetch, decode, execute, memory and writeback steps for R-type, lw, sw, beq, addi and j. It sits beside the datapath, reads op/func from the IR, and waits on a memory-ready handshake. All control outputs are decoded from the current state, gated by mem_ready where noted.

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl_func_dec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
// Holds the FSM state enum, opcode/func encodings, ALU operation codes and
// the PCSource / ALUSrcB mux select encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    ALU_WB   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type func field (IR[5:0])
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PCSource select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUSrcB select
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS controller.
// master: controller side (reads op/func/mem_ready, drives all controls).
// slave : datapath side (drives op/func/mem_ready, consumes controls).
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] func;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_op;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, func, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUSrcB, ALU_op, instr_done, illegal_op
  );

  modport slave (
    output op, func, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUSrcB, ALU_op, instr_done, illegal_op
  );

endinterface

// File: rtl/multicycle_ctrl_func_dec.sv
// mc_func_dec: combinational R-type func decoder.
// Ports:
//   i_func       - IR[5:0]
//   o_alu_op     - ALU operation for the func (add when illegal)
//   o_func_legal - 1 when func is one of add/sub/and/or/slt
module mc_func_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_op,
  output logic       o_func_legal
);

  always_comb begin
    o_alu_op     = ALU_ADD;
    o_func_legal = 1'b1;
    case (i_func)
      FUNC_ADD: o_alu_op = ALU_ADD;
      FUNC_SUB: o_alu_op = ALU_SUB;
      FUNC_AND: o_alu_op = ALU_AND;
      FUNC_OR:  o_alu_op = ALU_OR;
      FUNC_SLT: o_alu_op = ALU_SLT;
      default:  o_func_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS controller FSM (R-type, lw, sw, beq, addi, j).
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - multicycle_ctrl_if.master: op/func/mem_ready in, datapath controls out
//   instr_cnt - retired-instruction count (only when MC_INSTR_CNT_EN is defined)
// Optional feature macro: MC_INSTR_CNT_EN (adds parameter CNT_W and port instr_cnt).
// Control outputs are decoded combinationally from the state register, with
// mem_ready gating the memory-completion strobes in FETCH and MEM_WR.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
`ifdef MC_INSTR_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus
`ifdef MC_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0]     instr_cnt
`endif
);

  state_e     r_state;
  logic [2:0] w_func_alu_op;
  logic       w_func_legal;
  logic       w_op_legal;

  mc_func_dec u_func_dec (
    .i_func       (bus.func),
    .o_alu_op     (w_func_alu_op),
    .o_func_legal (w_func_legal)
  );

  always_comb begin
    w_op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: w_op_legal = 1'b1;
      OP_RTYPE:                            w_op_legal = w_func_legal;
      default:                             w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET: r_state <= FETCH;
        FETCH:   if (bus.mem_ready) r_state <= DECODE;
        DECODE: begin
          if (!w_op_legal) begin
            r_state <= FETCH;
          end else begin
            case (bus.op)
              OP_LW, OP_SW: r_state <= MEM_ADDR;
              OP_ADDI:      r_state <= ADDI_EX;
              OP_BEQ:       r_state <= BRANCH;
              OP_J:         r_state <= JUMP;
              default:      r_state <= EXEC;
            endcase
          end
        end
        // op is held stable from DECODE, so it still distinguishes lw/sw here.
        MEM_ADDR: r_state <= (bus.op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (bus.mem_ready) r_state <= MEM_WB;
        MEM_WR:   if (bus.mem_ready) r_state <= FETCH;
        EXEC:     r_state <= ALU_WB;
        ADDI_EX:  r_state <= ADDI_WB;
        MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP: r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = PCSRC_ALU;
    bus.ALUSrcB     = ALUB_REG;
    bus.ALU_op      = ALU_ADD;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    case (r_state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = ALUB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB    = ALUB_IMM_SH2;
        bus.illegal_op = ~w_op_legal;
      end
      MEM_ADDR, ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = ALUB_IMM;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.MemtoReg   = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEM_WR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALU_op  = w_func_alu_op;
      end
      ALU_WB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      ADDI_WB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALU_op      = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        bus.instr_done  = 1'b1;
      end
      JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = PCSRC_JUMP;
        bus.instr_done = 1'b1;
      end
      // S_RESET and unreachable encodings: everything low, including ALU_op.
      default: bus.ALU_op = 3'b000;
    endcase
  end

`ifdef MC_INSTR_CNT_EN
  logic [CNT_W-1:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (bus.instr_done) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-cycle vectors plus
// hand-written reset-abort and instruction-counter sequences.
module tb_multicycle_ctrl;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,
  //                RegWrite,RegDst, PCSource[1:0], ALUSrcB[1:0], ALU_op[2:0],
  //                instr_done, illegal_op}
  localparam logic [18:0] C_ZERO    = 19'b0000000000_00_00_000_00;
  localparam logic [18:0] C_FETCH1  = 19'b1001010000_00_01_010_00;
  localparam logic [18:0] C_FETCH0  = 19'b0001000000_00_01_010_00;
  localparam logic [18:0] C_DEC     = 19'b0000000000_00_11_010_00;
  localparam logic [18:0] C_DEC_ILL = 19'b0000000000_00_11_010_01;
  localparam logic [18:0] C_MADDR   = 19'b0000000100_00_10_010_00;
  localparam logic [18:0] C_MRD     = 19'b0011000000_00_00_010_00;
  localparam logic [18:0] C_MWB     = 19'b0000001010_00_00_010_10;
  localparam logic [18:0] C_MWR0    = 19'b0010100000_00_00_010_00;
  localparam logic [18:0] C_MWR1    = 19'b0010100000_00_00_010_10;
  localparam logic [18:0] C_EX_SUB  = 19'b0000000100_00_00_110_00;
  localparam logic [18:0] C_EX_SLT  = 19'b0000000100_00_00_111_00;
  localparam logic [18:0] C_ALUWB   = 19'b0000000011_00_00_010_10;
  localparam logic [18:0] C_ADDIWB  = 19'b0000000010_00_00_010_10;
  localparam logic [18:0] C_BRANCH  = 19'b0100000100_01_00_110_10;
  localparam logic [18:0] C_JUMP    = 19'b1000000000_10_00_010_10;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        mr;
    logic [18:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if u_if ();

`ifdef MC_INSTR_CNT_EN
  logic [31:0] instr_cnt;
  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (u_if.master),
    .instr_cnt (instr_cnt)
  );
`else
  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );
`endif

  function automatic logic [18:0] actual();
    return {u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead, u_if.MemWrite,
            u_if.IRWrite, u_if.MemtoReg, u_if.ALUSrcA, u_if.RegWrite, u_if.RegDst,
            u_if.PCSource, u_if.ALUSrcB, u_if.ALU_op, u_if.instr_done, u_if.illegal_op};
  endfunction

  task automatic check(input logic [18:0] exp, input string name);
    logic [18:0] act;
    act = actual();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, compare at the falling edge, then advance past the next rising edge.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic [18:0] exp, input string name);
    rst_n        = r;
    u_if.op      = op;
    u_if.func    = fn;
    u_if.mem_ready = mr;
    @(negedge clk);
    check(exp, name);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    u_if.op = '0;
    u_if.func = '0;
    u_if.mem_ready = 1'b0;

    // lw with mem_ready=1
    vecs.push_back('{1'b0, LW, 6'd0, 1'b1, C_ZERO,   "rst_low"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b1, C_ZERO,   "s_reset"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b1, C_FETCH1, "lw_fetch"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b1, C_DEC,    "lw_decode"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b0, C_MADDR,  "lw_memaddr"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b1, C_MRD,    "lw_memrd"});
    vecs.push_back('{1'b1, LW, 6'd0, 1'b0, C_MWB,    "lw_memwb"});
    // sw with three wait cycles
    vecs.push_back('{1'b1, SW, 6'd0, 1'b1, C_FETCH1, "sw_fetch"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b0, C_DEC,    "sw_decode"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b0, C_MADDR,  "sw_memaddr"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b0, C_MWR0,   "sw_wait1"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b0, C_MWR0,   "sw_wait2"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b0, C_MWR0,   "sw_wait3"});
    vecs.push_back('{1'b1, SW, 6'd0, 1'b1, C_MWR1,   "sw_done"});
    // R-type sub (with a fetch stall), then slt
    vecs.push_back('{1'b1, RT, 6'b100010, 1'b0, C_FETCH0, "sub_fetch_wait"});
    vecs.push_back('{1'b1, RT, 6'b100010, 1'b1, C_FETCH1, "sub_fetch"});
    vecs.push_back('{1'b1, RT, 6'b100010, 1'b0, C_DEC,    "sub_decode"});
    vecs.push_back('{1'b1, RT, 6'b100010, 1'b0, C_EX_SUB, "sub_exec"});
    vecs.push_back('{1'b1, RT, 6'b100010, 1'b0, C_ALUWB,  "sub_wb"});
    vecs.push_back('{1'b1, RT, 6'b101010, 1'b1, C_FETCH1, "slt_fetch"});
    vecs.push_back('{1'b1, RT, 6'b101010, 1'b1, C_DEC,    "slt_decode"});
    vecs.push_back('{1'b1, RT, 6'b101010, 1'b1, C_EX_SLT, "slt_exec"});
    vecs.push_back('{1'b1, RT, 6'b101010, 1'b1, C_ALUWB,  "slt_wb"});
    // addi, beq, j
    vecs.push_back('{1'b1, ADDI, 6'd0, 1'b1, C_FETCH1, "addi_fetch"});
    vecs.push_back('{1'b1, ADDI, 6'd0, 1'b1, C_DEC,    "addi_decode"});
    vecs.push_back('{1'b1, ADDI, 6'd0, 1'b0, C_MADDR,  "addi_ex"});
    vecs.push_back('{1'b1, ADDI, 6'd0, 1'b0, C_ADDIWB, "addi_wb"});
    vecs.push_back('{1'b1, BEQ,  6'd0, 1'b1, C_FETCH1, "beq_fetch"});
    vecs.push_back('{1'b1, BEQ,  6'd0, 1'b1, C_DEC,    "beq_decode"});
    vecs.push_back('{1'b1, BEQ,  6'd0, 1'b0, C_BRANCH, "beq_branch"});
    vecs.push_back('{1'b1, JMP,  6'd0, 1'b1, C_FETCH1, "j_fetch"});
    vecs.push_back('{1'b1, JMP,  6'd0, 1'b0, C_DEC,    "j_decode"});
    vecs.push_back('{1'b1, JMP,  6'd0, 1'b0, C_JUMP,   "j_jump"});
    // illegal op, then illegal func; each returns to FETCH
    vecs.push_back('{1'b1, 6'b111111, 6'd0, 1'b1, C_FETCH1,  "ill_op_fetch"});
    vecs.push_back('{1'b1, 6'b111111, 6'd0, 1'b1, C_DEC_ILL, "ill_op_decode"});
    vecs.push_back('{1'b1, RT, 6'b000111, 1'b1, C_FETCH1,  "ill_fn_fetch"});
    vecs.push_back('{1'b1, RT, 6'b000111, 1'b1, C_DEC_ILL, "ill_fn_decode"});
    vecs.push_back('{1'b1, RT, 6'b000111, 1'b0, C_FETCH0,  "ill_fn_back_fetch"});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].func, vecs[i].mr, vecs[i].exp, vecs[i].name);
    end

    // Reset abort during a stalled sw: outputs drop immediately, restart via S_RESET.
    step(1'b0, SW, 6'd0, 1'b0, C_ZERO,   "abort_pre_rst");
`ifdef MC_INSTR_CNT_EN
    n_tests++;
    if (instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_after_reset: got %0d, expected 0", instr_cnt);
    end
`endif
    step(1'b1, SW, 6'd0, 1'b0, C_ZERO,   "abort_s_reset");
    step(1'b1, SW, 6'd0, 1'b1, C_FETCH1, "abort_fetch");
    step(1'b1, SW, 6'd0, 1'b1, C_DEC,    "abort_decode");
    step(1'b1, SW, 6'd0, 1'b1, C_MADDR,  "abort_memaddr");
    step(1'b1, SW, 6'd0, 1'b0, C_MWR0,   "abort_memwr");
    #2 rst_n = 1'b0;
    #1 check(C_ZERO, "abort_async_zero");
    @(posedge clk);
    #1 check(C_ZERO, "abort_held_zero");
    step(1'b1, SW, 6'd0, 1'b1, C_ZERO,   "abort_restart_reset");
    step(1'b1, JMP, 6'd0, 1'b1, C_FETCH1, "abort_restart_fetch");

    // Two more jumps after the one already fetched: three completed instructions.
    step(1'b1, JMP, 6'd0, 1'b1, C_DEC,    "cnt_j1_decode");
    step(1'b1, JMP, 6'd0, 1'b1, C_JUMP,   "cnt_j1_jump");
    for (int k = 0; k < 2; k++) begin
      step(1'b1, JMP, 6'd0, 1'b1, C_FETCH1, "cnt_j_fetch");
      step(1'b1, JMP, 6'd0, 1'b1, C_DEC,    "cnt_j_decode");
      step(1'b1, JMP, 6'd0, 1'b1, C_JUMP,   "cnt_j_jump");
    end
`ifdef MC_INSTR_CNT_EN
    n_tests++;
    if (instr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL cnt_after_three: got %0d, expected 3", instr_cnt);
    end
`endif
    step(1'b1, JMP, 6'd0, 1'b0, C_FETCH0, "final_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
